// File: rtl/uart_rx_sync.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch and framing-error detection.
// Latency: o_Rx_DV / o_Rx_Frame_Err rise 1 + (HALF+1) + 9*(FULL+1) cycles after rx_s first reads low in IDLE.
// Backpressure: none; each good byte is a one-cycle strobe and o_Rx_Byte holds it until the next good byte.
module uart_rx_sync #(
    parameter int CLKS_PER_BIT = 54
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    // Start-bit centre and full-bit terminal counts (counter is 8 bits wide).
    localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] FULL = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        CLEANUP   = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    logic       sync1_q;
    logic       sync2_q;
    logic       rx_s;
    state_t     state_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic       rx_dv_q;
    logic [7:0] rx_byte_q;
    logic       frame_err_q;
    logic       active_q;

    // Two-flop synchroniser; resets to the idle-high line level so reset release never looks like a start bit.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_Rx_Serial;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s  = sync2_q;
    assign cnt_d = cnt_q + 8'd1;

    // Receive FSM with registered outputs; pulses default low so they never last more than one cycle.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            rx_dv_q     <= 1'b0;
            rx_byte_q   <= 8'd0;
            frame_err_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q     <= 8'd0;
                    bit_idx_q <= 3'd0;
                    active_q  <= 1'b0;
                    if (!rx_s) begin
                        state_q  <= START;
                        active_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF) begin
                        cnt_q <= 8'd0;
                        if (!rx_s) begin
                            state_q <= DATA;
                        end else begin
                            // Line went back high before the start-bit centre: treat as a glitch.
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL) begin
                        cnt_q            <= 8'd0;
                        shift_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= 3'd0;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL) begin
                        cnt_q    <= 8'd0;
                        active_q <= 1'b0;
                        if (rx_s) begin
                            rx_byte_q <= shift_q;
                            rx_dv_q   <= 1'b1;
                            state_q   <= CLEANUP;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                CLEANUP: begin
                    state_q <= IDLE;
                end
                WAIT_HIGH: begin
                    // A line held low (break) must not be re-read as a stream of frames.
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= 8'd0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_Rx_DV        = rx_dv_q;
    assign o_Rx_Byte      = rx_byte_q;
    assign o_Rx_Frame_Err = frame_err_q;
    assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx_sync.sv
// Self-checking bench for uart_rx_sync: scoreboard of expected bytes popped on each o_Rx_DV.
// Latency: stimulus is bit-level serial; DV expected 2 + 514 edges after the line is driven low.
// Backpressure: none; the monitor samples every falling edge.
module tb_uart_rx_sync;

    localparam int CPB       = 54;
    localparam int HALF      = (CPB - 1) / 2;
    localparam int FULL      = CPB - 1;
    localparam int PULSE_LAT = 1 + (HALF + 1) + 9 * (FULL + 1);
    localparam int DRIVE_LAT = 2 + PULSE_LAT;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       dv;
    logic [7:0] rx_byte;
    logic       fe;
    logic       active;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int dv_cnt   = 0;
    int fe_cnt   = 0;
    int last_dv_cyc = 0;
    int drive_cyc   = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_sync #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Rx_Serial   (rx),
        .o_Rx_DV       (dv),
        .o_Rx_Byte     (rx_byte),
        .o_Rx_Frame_Err(fe),
        .o_Rx_Active   (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each DV and polices pulse exclusivity.
    always @(negedge clk) begin
        if (!rst) begin
            if (dv || fe) begin
                checks++;
                if (dv && fe) begin
                    failures++;
                    $display("FAIL pulse_excl: dv=%0b fe=%0b, required not both high", dv, fe);
                end
                checks++;
                if (prev_pulse) begin
                    failures++;
                    $display("FAIL pulse_width: pulse high on 2 consecutive cycles at cyc %0d", cyc);
                end
            end
            if (dv) begin
                dv_cnt++;
                last_dv_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_dv: got byte %02h, scoreboard empty", rx_byte);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_byte !== e) begin
                        failures++;
                        $display("FAIL rx_byte: got %02h, required %02h", rx_byte, e);
                    end
                end
            end
            if (fe) fe_cnt++;
            prev_pulse = dv || fe;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Sends one 8N1 frame; checks o_Rx_Active in the middle of data bit 4.
    task automatic send_byte(input logic [7:0] b, input int period, input logic stop_val);
        rx = 1'b0;
        drive_cyc = cyc;
        repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == 4) begin
                repeat (period / 2) @(negedge clk);
                checks++;
                if (active !== 1'b1) begin
                    failures++;
                    $display("FAIL active_mid_frame: got %0b, required 1 (byte %02h)", active, b);
                end
                repeat (period - period / 2) @(negedge clk);
            end else begin
                repeat (period) @(negedge clk);
            end
        end
        rx = stop_val;
        repeat (period) @(negedge clk);
    endtask

    task automatic wait_dv(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (dv_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dv_cnt < target) begin
            failures++;
            $display("FAIL %s_timeout: dv_cnt=%0d, required %0d within %0d cycles", name, dv_cnt, target, budget);
        end
    endtask

    task automatic check_counts(input string name, input int dv_exp, input int fe_exp);
        checks++;
        if (dv_cnt !== dv_exp) begin
            failures++;
            $display("FAIL %s_dv_count: got %0d, required %0d", name, dv_cnt, dv_exp);
        end
        checks++;
        if (fe_cnt !== fe_exp) begin
            failures++;
            $display("FAIL %s_fe_count: got %0d, required %0d", name, fe_cnt, fe_exp);
        end
    endtask

    task automatic check_outputs_reset(input string name);
        checks++;
        if (dv !== 1'b0 || fe !== 1'b0 || active !== 1'b0 || rx_byte !== 8'h00) begin
            failures++;
            $display("FAIL %s: dv=%0b fe=%0b active=%0b byte=%02h, required 0 0 0 00",
                     name, dv, fe, active, rx_byte);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        check_outputs_reset("reset_values");
        rst = 1'b0;
        idle(20);
        check_outputs_reset("after_release_idle");
    endtask

    task automatic test_single_byte();
        int d0, f0;
        d0 = dv_cnt; f0 = fe_cnt;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, CPB, 1'b1);
        wait_dv(d0 + 1, 200, "single");
        checks++;
        if (last_dv_cyc - drive_cyc !== DRIVE_LAT) begin
            failures++;
            $display("FAIL single_latency: got %0d, required %0d", last_dv_cyc - drive_cyc, DRIVE_LAT);
        end
        idle(20);
        check_counts("single", d0 + 1, f0);
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL single_active_after: got %0b, required 0", active);
        end
    endtask

    task automatic test_back_to_back();
        int d0, f0;
        logic [7:0] bytes [3];
        d0 = dv_cnt; f0 = fe_cnt;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        for (int i = 0; i < 3; i++) exp_q.push_back(bytes[i]);
        for (int i = 0; i < 3; i++) send_byte(bytes[i], CPB, 1'b1);
        wait_dv(d0 + 3, 200, "b2b");
        idle(20);
        check_counts("b2b", d0 + 3, f0);
    endtask

    task automatic test_glitch();
        int d0, f0;
        d0 = dv_cnt; f0 = fe_cnt;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        idle(200);
        check_counts("glitch", d0, f0);
        checks++;
        if (rx_byte !== 8'h55 || active !== 1'b0) begin
            failures++;
            $display("FAIL glitch_hold: byte=%02h active=%0b, required 55 0", rx_byte, active);
        end
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, CPB, 1'b1);
        wait_dv(d0 + 1, 200, "glitch_follow");
        idle(20);
    endtask

    task automatic test_frame_err();
        int d0, f0;
        d0 = dv_cnt; f0 = fe_cnt;
        send_byte(8'h81, CPB, 1'b0);
        rx = 1'b0;
        repeat (2000) @(negedge clk);
        check_counts("frame_err", d0, f0 + 1);
        checks++;
        if (rx_byte !== 8'h3C) begin
            failures++;
            $display("FAIL frame_err_byte: got %02h, required 3c", rx_byte);
        end
        idle(50);
        check_counts("frame_err_release", d0, f0 + 1);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, CPB, 1'b1);
        wait_dv(d0 + 1, 200, "frame_err_follow");
        idle(20);
    endtask

    task automatic test_reset_mid_frame();
        int d0, f0;
        logic [7:0] b;
        b = 8'hC3;
        d0 = dv_cnt; f0 = fe_cnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        #3 rst = 1'b1;
        #1 check_outputs_reset("reset_mid_frame");
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle(700);
        check_counts("reset_mid", d0, f0);
        check_outputs_reset("reset_mid_after_release");
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, CPB, 1'b1);
        wait_dv(d0 + 1, 200, "reset_follow");
        idle(20);
    endtask

    task automatic test_baud_skew();
        int d0, f0;
        int periods [2];
        d0 = dv_cnt; f0 = fe_cnt;
        periods[0] = 52; periods[1] = 56;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'h96);
            send_byte(8'h96, periods[i], 1'b1);
            wait_dv(d0 + i + 1, 200, "skew");
            idle(30);
        end
        check_counts("skew", d0 + 2, f0);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_baud_skew();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d bytes never received", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
